// File: rtl/apb4_master_pkg.sv
// Shared types and default constants for the APB4 requester.
package apb4_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam int unsigned DEF_ADDR_WIDTH = 32;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_TIMEOUT    = 256;

  // Wait-counter width: ceil(log2(tmo+1)), at least one bit so a disabled
  // timeout still yields a legal vector.
  function automatic int unsigned cnt_width(input int unsigned tmo);
    int unsigned w;
    w = unsigned'($clog2(tmo + 1));
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/dffr.sv
// Shared register primitive: D flop with asynchronous active-low reset.
module dffr #(
  parameter int unsigned     WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Register with asynchronous reset to RST_VAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RST_VAL;
    else        q <= d;
  end

endmodule

// File: rtl/apb4_master.sv
// APB4 requester: one outstanding transaction, command/response handshakes,
// optional ACCESS-phase timeout.
module apb4_master
  import apb4_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_strb_i,
  input  logic [2:0]              req_prot_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_tmo_o,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [2:0]              pprot,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int unsigned    SW       = DATA_WIDTH / 8;
  localparam int unsigned    CW       = cnt_width(TIMEOUT);
  localparam bit             TMO_EN   = (TIMEOUT != 0);
  localparam logic [CW-1:0]  TMO_LAST = TMO_EN ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0]  CNT_MAX  = '1;

  state_e                 state_d;
  logic [1:0]             state_q;
  logic                   write_d, write_q;
  logic [ADDR_WIDTH-1:0]  addr_d, addr_q;
  logic [DATA_WIDTH-1:0]  wdata_d, wdata_q;
  logic [SW-1:0]          strb_d, strb_q;
  logic [2:0]             prot_d, prot_q;
  logic [CW-1:0]          cnt_d, cnt_q;
  logic [DATA_WIDTH-1:0]  rdata_d, rdata_q;
  logic                   err_d, err_q;
  logic                   tmo_d, tmo_q;

  // Next-state, holding-register, wait-counter and response-register logic.
  always_comb begin
    state_d = state_e'(state_q);
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    prot_d  = prot_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          write_d = req_write_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          strb_d  = req_write_i ? req_strb_i : '0;
          prot_d  = req_prot_i;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = '0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        // pready wins over the timeout on the final allowed cycle.
        if (pready) begin
          rdata_d = write_q ? '0 : prdata;
          err_d   = pslverr;
          tmo_d   = 1'b0;
          state_d = ST_RESP;
        end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = ST_RESP;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  dffr #(.WIDTH(2), .RST_VAL(ST_IDLE)) u_state (
    .clk(pclk), .rst_n(presetn), .d(state_d), .q(state_q));
  dffr #(.WIDTH(1)) u_write (
    .clk(pclk), .rst_n(presetn), .d(write_d), .q(write_q));
  dffr #(.WIDTH(ADDR_WIDTH)) u_addr (
    .clk(pclk), .rst_n(presetn), .d(addr_d), .q(addr_q));
  dffr #(.WIDTH(DATA_WIDTH)) u_wdata (
    .clk(pclk), .rst_n(presetn), .d(wdata_d), .q(wdata_q));
  dffr #(.WIDTH(SW)) u_strb (
    .clk(pclk), .rst_n(presetn), .d(strb_d), .q(strb_q));
  dffr #(.WIDTH(3)) u_prot (
    .clk(pclk), .rst_n(presetn), .d(prot_d), .q(prot_q));
  dffr #(.WIDTH(CW)) u_cnt (
    .clk(pclk), .rst_n(presetn), .d(cnt_d), .q(cnt_q));
  dffr #(.WIDTH(DATA_WIDTH)) u_rdata (
    .clk(pclk), .rst_n(presetn), .d(rdata_d), .q(rdata_q));
  dffr #(.WIDTH(1)) u_err (
    .clk(pclk), .rst_n(presetn), .d(err_d), .q(err_q));
  dffr #(.WIDTH(1)) u_tmo (
    .clk(pclk), .rst_n(presetn), .d(tmo_d), .q(tmo_q));

  assign req_ready_o = (state_q == ST_IDLE);
  assign psel        = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign penable     = (state_q == ST_ACCESS);
  assign pwrite      = write_q;
  assign paddr       = addr_q;
  assign pwdata      = wdata_q;
  assign pstrb       = strb_q;
  assign pprot       = prot_q;
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign rsp_tmo_o   = tmo_q;

endmodule

// File: tb/tb_apb4_master.sv
// Directed and randomized bench for apb4_master with TIMEOUT=4.
module tb_apb4_master;

  localparam int unsigned TMO = 4;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        req_valid_i, req_ready_o, req_write_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [3:0]  req_strb_i;
  logic [2:0]  req_prot_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o, rsp_tmo_o;
  logic [31:0] paddr, pwdata, prdata;
  logic [2:0]  pprot;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [3:0]  pstrb;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  apb4_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TMO)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_write_i(req_write_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_strb_i(req_strb_i), .req_prot_i(req_prot_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .rsp_tmo_o(rsp_tmo_o),
    .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata), .pready(pready), .pslverr(pslverr));

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // One full transaction; expectations come from the protocol rules:
  // a timeout happens when the slave would need TMO or more wait cycles.
  task automatic run_txn(input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input logic [2:0] prot, input logic [31:0] rd,
                         input int unsigned waits, input logic slverr,
                         input int unsigned bp);
    logic        tmo_exp, err_exp;
    logic [31:0] rdata_exp;
    logic [3:0]  strb_exp;
    int unsigned n_acc;
    tmo_exp   = (TMO != 0) && (waits >= TMO);
    n_acc     = tmo_exp ? TMO : waits + 1;
    rdata_exp = (tmo_exp || wr) ? 32'h0 : rd;
    err_exp   = tmo_exp || slverr;
    strb_exp  = wr ? strb : 4'h0;

    chk("idle_req_ready", req_ready_o, 1);
    req_valid_i = 1'b1; req_write_i = wr; req_addr_i = addr;
    req_wdata_i = wdata; req_strb_i = strb; req_prot_i = prot;
    step();
    req_valid_i = 1'b0;
    req_write_i = 1'($urandom); req_addr_i = $urandom; req_wdata_i = $urandom;
    req_strb_i = 4'($urandom); req_prot_i = 3'($urandom);

    chk("setup_psel", psel, 1);
    chk("setup_penable", penable, 0);
    chk("setup_req_ready", req_ready_o, 0);
    chk("setup_bus", {pwrite, pprot, pstrb, paddr, pwdata[23:0]},
        {wr, prot, strb_exp, addr, wdata[23:0]});
    step();

    for (int unsigned k = 0; k < n_acc; k++) begin
      chk("access_psel_penable", {psel, penable}, 2'b11);
      chk("access_rsp_valid", rsp_valid_o, 0);
      chk("access_bus", {pwrite, pprot, pstrb, paddr, pwdata[23:0]},
          {wr, prot, strb_exp, addr, wdata[23:0]});
      chk("access_pwdata_hi", pwdata[31:24], wdata[31:24]);
      if (k == waits) begin
        pready = 1'b1; prdata = rd; pslverr = slverr;
      end else begin
        pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
      end
      step();
      pready = 1'b0; pslverr = 1'b0;
    end

    for (int unsigned b = 0; b <= bp; b++) begin
      chk("resp_valid", rsp_valid_o, 1);
      chk("resp_rdata", rsp_rdata_o, rdata_exp);
      chk("resp_err_tmo", {rsp_err_o, rsp_tmo_o}, {err_exp, tmo_exp});
      chk("resp_bus_idle", {psel, penable, req_ready_o}, 3'b000);
      if (b == bp) begin
        rsp_ready_i = 1'b1;
        req_valid_i = 1'b1;
      end
      step();
    end
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b0;
    chk("post_resp_idle", {rsp_valid_o, psel, req_ready_o}, 3'b001);
  endtask

  initial begin
    presetn = 1'b0;
    req_valid_i = 0; req_write_i = 0; req_addr_i = 0; req_wdata_i = 0;
    req_strb_i = 0; req_prot_i = 0; rsp_ready_i = 0;
    prdata = 0; pready = 0; pslverr = 0;
    step();
    step();
    chk("rst_ctrl", {psel, penable, pwrite, rsp_valid_o, rsp_err_o, rsp_tmo_o}, 6'b0);
    chk("rst_data", {paddr, pwdata, pstrb, pprot}, 71'h0);
    chk("rst_rdata", rsp_rdata_o, 0);
    presetn = 1'b1;
    step();
    chk("rst_req_ready", req_ready_o, 1);

    // Zero-wait write.
    run_txn(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 3'b000, 32'h0, 0, 1'b0, 0);
    // Read with three wait states.
    run_txn(1'b0, 32'h100, 32'h0, 4'hF, 3'b010, 32'h12345678, 3, 1'b0, 0);
    // Slave error.
    run_txn(1'b0, 32'h200, 32'h0, 4'h0, 3'b001, 32'hCAFEF00D, 0, 1'b1, 0);
    // Timeout: slave never ready.
    run_txn(1'b0, 32'h300, 32'h0, 4'h0, 3'b000, 32'hAAAA5555, 10, 1'b0, 0);
    // pready on the final allowed ACCESS cycle completes normally.
    run_txn(1'b0, 32'h304, 32'h0, 4'h0, 3'b000, 32'h0BADF00D, TMO - 1, 1'b0, 0);
    // Response backpressure.
    run_txn(1'b1, 32'h400, 32'h11223344, 4'h5, 3'b111, 32'h0, 1, 1'b0, 5);

    // Reset in the middle of ACCESS.
    req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 32'h500;
    req_wdata_i = 32'h0; req_strb_i = 4'h0; req_prot_i = 3'b000;
    step();
    req_valid_i = 1'b0;
    step();
    step();
    chk("pre_rst_access", {psel, penable}, 2'b11);
    #2 presetn = 1'b0;
    #1;
    chk("rst_async_bus", {psel, penable}, 2'b00);
    chk("rst_async_rsp", rsp_valid_o, 0);
    step();
    step();
    presetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_release", {rsp_valid_o, psel, req_ready_o}, 3'b001);
      chk("rst_release_paddr", paddr, 0);
      step();
    end

    // Randomized transactions, including some that time out.
    for (int i = 0; i < 24; i++) begin
      run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom),
              $urandom, $urandom_range(0, 5), 1'($urandom), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/apb4_master.md
APB4_MASTER -- requirements
Module: apb4_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT, default 256, max ACCESS cycles waiting for pready; 0 disables timeout.
REQ-004 SHALL have port pclk  in  1  sole clock.
REQ-005 SHALL have port presetn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports req_valid_i in 1, req_ready_o out 1: command handshake.
REQ-007 SHALL have ports req_write_i in 1, req_addr_i in ADDR_WIDTH, req_wdata_i in DATA_WIDTH, req_strb_i in DATA_WIDTH/8, req_prot_i in 3: command payload.
REQ-008 SHALL have ports rsp_valid_o out 1, rsp_ready_i in 1: response handshake.
REQ-009 SHALL have ports rsp_rdata_o out DATA_WIDTH, rsp_err_o out 1 (pslverr or timeout), rsp_tmo_o out 1 (timeout only).
REQ-010 SHALL have APB4 requester ports paddr out ADDR_WIDTH, pprot out 3, psel out 1, penable out 1, pwrite out 1, pwdata out DATA_WIDTH, pstrb out DATA_WIDTH/8, prdata in DATA_WIDTH, pready in 1, pslverr in 1.

Function
REQ-011 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP; at most one transaction outstanding.
REQ-012 SHALL drive req_ready_o = 1 only in IDLE; command accepted on cycle where req_valid_i && req_ready_o.
REQ-013 SHALL on acceptance latch write, addr, wdata, strb, prot into holding registers and enter SETUP next cycle.
REQ-014 SHALL in SETUP drive psel=1, penable=0, bus payload from holding registers; unconditionally enter ACCESS next cycle.
REQ-015 SHALL in ACCESS drive psel=1, penable=1, payload unchanged from SETUP.
REQ-016 SHALL in ACCESS with pready=1 capture prdata (reads only; writes return 0) and pslverr into response registers and enter RESP.
REQ-017 SHALL in ACCESS count wait cycles; if TIMEOUT!=0 and TIMEOUT cycles elapse with pready=0, abort: rsp_err_o=1, rsp_tmo_o=1, rsp_rdata_o=0, enter RESP.
REQ-018 SHALL treat pready=1 on the same cycle the count reaches TIMEOUT as a normal completion, not a timeout.
REQ-019 SHALL drive psel=0, penable=0 in IDLE and RESP; pstrb SHALL be 0 for reads.
REQ-020 SHALL in RESP hold rsp_valid_o=1 and response data stable until rsp_ready_i=1, then enter IDLE.
REQ-021 SHALL give minimum latency: accept at cycle N, SETUP N+1, ACCESS N+2, rsp_valid_o high at N+3 when pready=1 at N+2.
REQ-022 SHALL not accept a new command in the cycle rsp handshake completes (next accept earliest one cycle later, in IDLE).
REQ-023 SHALL ignore req_* payload changes outside the acceptance cycle.
REQ-024 SHALL clear the wait counter on entry to ACCESS; counter width ceil(log2(TIMEOUT+1)), saturating.

Reset
REQ-025 SHALL on presetn low, at any state including mid-ACCESS, return to IDLE immediately, abandoning the transaction without response.
REQ-026 SHALL reset psel, penable, pwrite, rsp_valid_o, rsp_err_o, rsp_tmo_o to 0; paddr, pwdata, pstrb, pprot, rsp_rdata_o to 0; req_ready_o to 1 after reset deasserts.

Structure
REQ-027 SHALL place FSM state enum and default parameter constants in shared package apb4_master_pkg.
REQ-028 SHALL build all state, holding, counter and response registers from the codebase's shared dffr register primitive; no further sub-module.

Verification
REQ-029 SHALL test write: cmd addr 0x4, wdata 0xDEADBEEF, strb 0xF, slave pready=1 -> SETUP/ACCESS one cycle each, rsp at N+3, err=0, rdata=0.
REQ-030 SHALL test read with 3 wait states: slave returns prdata 0x12345678 after pready low 3 cycles -> payload stable throughout, rsp_rdata_o=0x12345678, err=0.
REQ-031 SHALL test pslverr: slave pready=1, pslverr=1 -> rsp_err_o=1, rsp_tmo_o=0.
REQ-032 SHALL test timeout with TIMEOUT=4, pready held 0 -> abort after 4 ACCESS cycles, err=1, tmo=1, psel=0 next cycle; pready on 4th cycle -> normal completion.
REQ-033 SHALL test backpressure: rsp_ready_i low 5 cycles -> rsp stable, req_ready_o=0, no new psel.
REQ-034 SHALL test reset asserted during ACCESS -> psel/penable 0 immediately, rsp_valid_o never asserted, req_ready_o=1 after release.
